fire_bias_relu_stage: RTL
=========================

// Module: fire_bias_relu_stage
// PURPOSE
//  Consumer side of the per-layer bias ROM interface (bias_mem[0:15]).
//  - Accepts one conv accumulator per output channel, channel-sequential.
//  - Adds that channel's bias, applies ReLU, arithmetic-shifts and saturates.
//  - Emits activations to the next fire/expand stage through a 2-stage stallable
//    pipeline with valid/ready on both sides.
// PARAMETERS
//  NUM_CH  16  output channels per pixel; size of bias_mem; counter wraps here
//  ACC_W   32  signed accumulator input width
//  SHIFT   8   arithmetic right shift applied after bias add (fixed-point rescale)
//  OUT_W   16  signed output width; result is always >= 0
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  bias_mem   in   33 x NUM_CH  bias per channel; bits [31:0] are two's-complement, bit 32 ignored
//  in_data    in   ACC_W      signed accumulator for current channel
//  in_valid   in   1          in_data/in_last valid
//  in_last    in   1          marks last channel of a pixel
//  in_ready   out  1          stage can accept this cycle
//  out_data   out  OUT_W      activation
//  out_ch     out  clog2(NUM_CH)  channel index of out_data
//  out_last   out  1          last channel of pixel
//  out_valid  out  1          output valid
//  out_ready  in   1          downstream accepts
//  err_seq    out  1          sticky: in_last misaligned with channel counter
// BEHAVIOUR
//  Reset (async, rst_n=0): ch_cnt=0, both stage valids=0, out_valid=0,
//   out_data=0, out_ch=0, out_last=0, err_seq=0. in_ready=1 after reset.
//  Handshake: transfer when valid&&ready on a side. adv2 = !v2 || out_ready;
//   adv1 = !v1 || adv2; in_ready = adv1 (combinational). Data held stable while
//   out_valid && !out_ready. Full throughput 1/cycle; latency 2 cycles in->out.
//  Stage 1 (on input transfer): sum = sext(in_data,ACC_W+1) + sext(bias_mem[ch_cnt][31:0],ACC_W+1);
//   captures ch_cnt and in_last alongside.
//  Stage 2: r = sum<0 ? 0 : sum >>> SHIFT; out_data = (r > 2^(OUT_W-1)-1) ?
//   2^(OUT_W-1)-1 : r[OUT_W-1:0]. No wrap-around ever.
//  Channel counter (advances only on input transfer):
//   - in_last=1 && ch_cnt==NUM_CH-1 -> ch_cnt=0 (normal end of pixel).
//   - in_last=0 && ch_cnt<NUM_CH-1 -> ch_cnt+1.
//   - in_last=1 && ch_cnt!=NUM_CH-1 -> err_seq=1, ch_cnt=0 (resync to last).
//   - in_last=0 && ch_cnt==NUM_CH-1 -> err_seq=1, ch_cnt=0 (wrap).
//   - Beat still processed with bias of ch_cnt before update; out_last=in_last.
//  err_seq clears only on reset.
//  Simultaneous in/out transfer with pipe full: both stages shift, no bubble.
//  Reset mid-pixel: in-flight beats discarded, next beat treated as channel 0.
//  bias_mem is sampled combinationally in the input-transfer cycle; it is constant
//   per layer and needs no handshake.
// TESTING (bias_mem: ch1=845, ch3=-480, ch13=2131, ch15=-1; SHIFT=8, OUT_W=16)
//  1 Stream 16 beats in_data=0, in_last on beat 15, out_ready=1 -> out ch1=3,
//    ch3=0, ch13=8, ch15=0; outputs 2 cycles after inputs; out_last on ch15; err_seq=0.
//  2 ch3 in_data=100 -> sum=-380 -> out_data=0; ch13 in_data=32'h7FFFFFFF ->
//    saturates to 32767; ch1 in_data=-846 -> 0; ch1 in_data=256-845 -> 1.
//  3 out_ready=0 for 5 cycles mid-stream -> in_ready drops after 2 accepted
//    beats, out_data/out_ch stable, no beat lost/duplicated on release.
//  4 in_last asserted at channel 5 -> err_seq=1, next beat uses ch0 bias;
//    16 beats without in_last -> err_seq=1, counter wraps to 0.
//  5 Assert rst_n=0 with pipe full -> out_valid=0 immediately (async);
//    after release first beat reports out_ch=0.
//  6 Random valid/ready toggling, 1000 beats vs reference model -> exact
//    match of out_data/out_ch/out_last sequence.

Source files
------------

// File: rtl/fire_bias_relu_stage.sv
// Bias-add, ReLU, rescale and saturate stage fed channel-sequentially from a conv
// accumulator; two-stage stallable valid/ready pipeline towards the next fire stage.
module fire_bias_relu_stage #(
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned SHIFT  = 8,
  parameter int unsigned OUT_W  = 16,
  localparam int unsigned CH_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [32:0]       bias_mem [NUM_CH],
  input  logic [ACC_W-1:0]  in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_seq
);

  localparam int unsigned SUM_W   = ACC_W + 1;
  localparam int unsigned BIAS_W  = 32;
  localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(NUM_CH - 1);
  localparam logic [SUM_W-1:0] OUT_MAX = SUM_W'((64'd1 << (OUT_W - 1)) - 64'd1);

  // Stage 1: biased sum plus side-band
  logic              v1_q, v1_d;
  logic [SUM_W-1:0]  sum1_q, sum1_d;
  logic [CH_W-1:0]   ch1_q, ch1_d;
  logic              last1_q, last1_d;

  // Stage 2: registered outputs
  logic              v2_q, v2_d;
  logic [OUT_W-1:0]  data2_q, data2_d;
  logic [CH_W-1:0]   ch2_q, ch2_d;
  logic              last2_q, last2_d;

  // Channel sequencing
  logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
  logic              err_q, err_d;

  logic              adv1_c, adv2_c, in_xfer_c;
  logic [BIAS_W-1:0] bias_sel_c;
  logic [SUM_W-1:0]  sum_c;
  logic [SUM_W-1:0]  shifted_c;
  logic [OUT_W-1:0]  act_c;
  logic              bias_msb_unused;

  // Bit 32 of each bias word carries nothing for this stage
  always_comb begin
    bias_msb_unused = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      bias_msb_unused = bias_msb_unused ^ bias_mem[i][32];
    end
  end

  // Pipeline advance: a stage may load when it is empty or its successor advances
  always_comb begin
    adv2_c    = !v2_q || out_ready;
    adv1_c    = !v1_q || adv2_c;
    in_xfer_c = in_valid && adv1_c;
  end

  // Bias lookup uses the counter value before this beat updates it
  always_comb begin
    bias_sel_c = bias_mem[ch_cnt_q][BIAS_W-1:0];
    sum_c      = {in_data[ACC_W-1], in_data}
               + {{(SUM_W - BIAS_W){bias_sel_c[BIAS_W-1]}}, bias_sel_c};
  end

  // ReLU, arithmetic rescale and clamp to the positive output range
  always_comb begin
    shifted_c = SUM_W'($signed(sum1_q) >>> SHIFT);
    act_c     = '0;
    if (!sum1_q[SUM_W-1]) begin
      if (shifted_c > OUT_MAX) begin
        act_c = OUT_MAX[OUT_W-1:0];
      end else begin
        act_c = shifted_c[OUT_W-1:0];
      end
    end
  end

  // Next-state for pipeline, channel counter and sequencing error
  always_comb begin
    v1_d     = v1_q;
    sum1_d   = sum1_q;
    ch1_d    = ch1_q;
    last1_d  = last1_q;
    v2_d     = v2_q;
    data2_d  = data2_q;
    ch2_d    = ch2_q;
    last2_d  = last2_q;
    ch_cnt_d = ch_cnt_q;
    err_d    = err_q;

    if (adv2_c) begin
      v2_d = v1_q;
      if (v1_q) begin
        data2_d = act_c;
        ch2_d   = ch1_q;
        last2_d = last1_q;
      end
    end

    if (adv1_c) begin
      v1_d = in_valid;
      if (in_xfer_c) begin
        sum1_d  = sum_c;
        ch1_d   = ch_cnt_q;
        last1_d = in_last;
      end
    end

    // Any in_last / counter disagreement flags an error and resyncs to channel 0
    if (in_xfer_c) begin
      if (in_last || (ch_cnt_q == CH_MAX)) begin
        ch_cnt_d = '0;
        if (in_last != (ch_cnt_q == CH_MAX)) begin
          err_d = 1'b1;
        end
      end else begin
        ch_cnt_d = ch_cnt_q + CH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      sum1_q   <= '0;
      ch1_q    <= '0;
      last1_q  <= 1'b0;
      v2_q     <= 1'b0;
      data2_q  <= '0;
      ch2_q    <= '0;
      last2_q  <= 1'b0;
      ch_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      sum1_q   <= sum1_d;
      ch1_q    <= ch1_d;
      last1_q  <= last1_d;
      v2_q     <= v2_d;
      data2_q  <= data2_d;
      ch2_q    <= ch2_d;
      last2_q  <= last2_d;
      ch_cnt_q <= ch_cnt_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = adv1_c;
  assign out_valid = v2_q;
  assign out_data  = data2_q;
  assign out_ch    = ch2_q;
  assign out_last  = last2_q;
  assign err_seq   = err_q;

endmodule
